// File: rtl/frog_move_ctrl.sv
// Frogger player controller: button edges -> grid moves, tile resolution, collision respawn, score.
// Optional FROG_LIVES_EN adds a 2-bit lives counter that locks movement once it reaches zero.
module frog_move_ctrl #(
  parameter int c_GAME_WIDTH    = 20,
  parameter int c_GAME_HEIGHT   = 15,
  parameter int c_START_X       = 10,
  parameter int c_START_Y       = 14,
  parameter int c_MOVE_COOLDOWN = 8
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Up_Mvt,
  input  logic       i_Down_Mvt,
  input  logic       i_Left_Mvt,
  input  logic       i_Right_Mvt,
  input  logic       i_Collided,
  input  logic [2:0] i_Bitmap_Data,
`ifdef FROG_LIVES_EN
  output logic [1:0] o_Lives,
`endif
  output logic [5:0] o_Frogger_X,
  output logic [5:0] o_Frogger_Y,
  output logic [6:0] o_Score
);

  localparam int CW = $clog2(c_MOVE_COOLDOWN + 1);

  typedef enum logic {IDLE, CHECK} state_t;

  state_t        state_q, state_d;
  logic [5:0]    x_q, x_d, y_q, y_d;
  logic [5:0]    prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [6:0]    score_q, score_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [3:0]    hist_q, hist_d;
  logic [3:0]    btn, press;
  logic [5:0]    tx, ty;
  logic          move_ok;
  logic          locked;
`ifdef FROG_LIVES_EN
  logic [1:0]    lives_q, lives_d;
`endif

  // Bit order {up, down, left, right}; a press is a 0->1 level change.
  assign btn   = {i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt};
  assign press = btn & ~hist_q;

`ifdef FROG_LIVES_EN
  assign locked = (lives_q == 2'd0);
`else
  assign locked = 1'b0;
`endif

  // Only the highest-priority edge is considered; its target decides legality.
  always_comb begin
    tx      = x_q;
    ty      = y_q;
    move_ok = 1'b0;
    if (press[3]) begin
      ty      = y_q - 6'd1;
      move_ok = (y_q != 6'd0);
    end else if (press[2]) begin
      ty      = y_q + 6'd1;
      move_ok = (y_q != 6'(c_GAME_HEIGHT - 1));
    end else if (press[1]) begin
      tx      = x_q - 6'd1;
      move_ok = (x_q != 6'd0);
    end else if (press[0]) begin
      tx      = x_q + 6'd1;
      move_ok = (x_q != 6'(c_GAME_WIDTH - 1));
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    prev_x_d = prev_x_q;
    prev_y_d = prev_y_q;
    score_d  = score_q;
    hist_d   = btn;
    cool_d   = (cool_q != '0) ? cool_q - CW'(1) : cool_q;
`ifdef FROG_LIVES_EN
    lives_d  = lives_q;
`endif
    if (i_Collided) begin
      state_d = IDLE;
      x_d     = 6'(c_START_X);
      y_d     = 6'(c_START_Y);
      cool_d  = '0;
`ifdef FROG_LIVES_EN
      if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (move_ok && cool_q == '0 && !locked) begin
            prev_x_d = x_q;
            prev_y_d = y_q;
            x_d      = tx;
            y_d      = ty;
            cool_d   = CW'(c_MOVE_COOLDOWN);
            state_d  = CHECK;
          end
        end
        CHECK: begin
          state_d = IDLE;
          case (i_Bitmap_Data)
            3'd0: begin
              x_d = prev_x_q;
              y_d = prev_y_q;
            end
            3'd2: begin
              x_d = 6'(c_START_X);
              y_d = 6'(c_START_Y);
`ifdef FROG_LIVES_EN
              if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
`endif
            end
            3'd4: begin
              score_d = (score_q == 7'd99) ? 7'd0 : score_q + 7'd1;
              x_d     = 6'(c_START_X);
              y_d     = 6'(c_START_Y);
            end
            default: ;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      x_q      <= 6'(c_START_X);
      y_q      <= 6'(c_START_Y);
      prev_x_q <= 6'(c_START_X);
      prev_y_q <= 6'(c_START_Y);
      score_q  <= 7'd0;
      cool_q   <= '0;
      hist_q   <= 4'b1111;
`ifdef FROG_LIVES_EN
      lives_q  <= 2'd3;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      prev_x_q <= prev_x_d;
      prev_y_q <= prev_y_d;
      score_q  <= score_d;
      cool_q   <= cool_d;
      hist_q   <= hist_d;
`ifdef FROG_LIVES_EN
      lives_q  <= lives_d;
`endif
    end
  end

  assign o_Frogger_X = x_q;
  assign o_Frogger_Y = y_q;
  assign o_Score     = score_q;
`ifdef FROG_LIVES_EN
  assign o_Lives     = lives_q;
`endif

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Directed bench for frog_move_ctrl: per-cycle vector table plus sequences for grid edges,
// score wrap, reset mid-move and (with FROG_LIVES_EN) the lives counter.
module tb_frog_move_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, left, right, col;
  logic [2:0] tile;
  logic [5:0] fx, fy;
  logic [6:0] score;
`ifdef FROG_LIVES_EN
  logic [1:0] lives;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frog_move_ctrl dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Up_Mvt      (up),
    .i_Down_Mvt    (down),
    .i_Left_Mvt    (left),
    .i_Right_Mvt   (right),
    .i_Collided    (col),
    .i_Bitmap_Data (tile),
`ifdef FROG_LIVES_EN
    .o_Lives       (lives),
`endif
    .o_Frogger_X   (fx),
    .o_Frogger_Y   (fy),
    .o_Score       (score)
  );

  // One row = inputs held for n cycles; outputs expected after every one of those edges.
  typedef struct {
    logic [3:0] btn;
    logic       col;
    logic [2:0] tile;
    int         n;
    logic [5:0] ex;
    logic [5:0] ey;
    logic [6:0] es;
  } vec_t;

  vec_t tbl[26];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [5:0] ex, input logic [5:0] ey,
                       input logic [6:0] es);
    checks++;
    if (fx !== ex || fy !== ey || score !== es) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d score=%0d, want x=%0d y=%0d score=%0d",
               nm, fx, fy, score, ex, ey, es);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {up, down, left, right} = b;
  endtask

  initial begin
    logic [6:0] s;
    rst = 1'b1; up = 1'b1; down = 1'b0; left = 1'b0; right = 1'b0; col = 1'b0; tile = 3'd1;

    //            btn      col   tile  n   x      y      score
    tbl[0]  = '{4'b0000, 1'b0, 3'd1, 1, 6'd10, 6'd14, 7'd0};  // up released
    tbl[1]  = '{4'b1000, 1'b0, 3'd1, 1, 6'd10, 6'd13, 7'd0};  // up press
    tbl[2]  = '{4'b0000, 1'b0, 3'd1, 2, 6'd10, 6'd13, 7'd0};  // road keeps
    tbl[3]  = '{4'b1000, 1'b0, 3'd1, 1, 6'd10, 6'd13, 7'd0};  // cooldown drop
    tbl[4]  = '{4'b0000, 1'b0, 3'd1, 5, 6'd10, 6'd13, 7'd0};
    tbl[5]  = '{4'b0100, 1'b0, 3'd1, 1, 6'd10, 6'd14, 7'd0};  // down
    tbl[6]  = '{4'b0000, 1'b0, 3'd1, 8, 6'd10, 6'd14, 7'd0};
    tbl[7]  = '{4'b0100, 1'b0, 3'd1, 1, 6'd10, 6'd14, 7'd0};  // down at bottom
    tbl[8]  = '{4'b0000, 1'b0, 3'd1, 1, 6'd10, 6'd14, 7'd0};
    tbl[9]  = '{4'b1010, 1'b0, 3'd1, 1, 6'd10, 6'd13, 7'd0};  // up+left: up wins
    tbl[10] = '{4'b0000, 1'b0, 3'd1, 8, 6'd10, 6'd13, 7'd0};
    tbl[11] = '{4'b0010, 1'b0, 3'd0, 1, 6'd9,  6'd13, 7'd0};  // onto wall
    tbl[12] = '{4'b0000, 1'b0, 3'd0, 1, 6'd10, 6'd13, 7'd0};  // bounced back
    tbl[13] = '{4'b0000, 1'b0, 3'd1, 7, 6'd10, 6'd13, 7'd0};
    tbl[14] = '{4'b0001, 1'b0, 3'd2, 1, 6'd11, 6'd13, 7'd0};  // onto water
    tbl[15] = '{4'b0000, 1'b0, 3'd2, 1, 6'd10, 6'd14, 7'd0};  // drowned
    tbl[16] = '{4'b0000, 1'b0, 3'd1, 7, 6'd10, 6'd14, 7'd0};
    tbl[17] = '{4'b1000, 1'b0, 3'd4, 1, 6'd10, 6'd13, 7'd0};  // onto lily
    tbl[18] = '{4'b0000, 1'b0, 3'd4, 1, 6'd10, 6'd14, 7'd1};  // scored
    tbl[19] = '{4'b0000, 1'b0, 3'd1, 7, 6'd10, 6'd14, 7'd1};
    tbl[20] = '{4'b1000, 1'b0, 3'd4, 1, 6'd10, 6'd13, 7'd1};
    tbl[21] = '{4'b0000, 1'b1, 3'd4, 1, 6'd10, 6'd14, 7'd1};  // hit during check
    tbl[22] = '{4'b1000, 1'b0, 3'd1, 1, 6'd10, 6'd13, 7'd1};  // cooldown cleared
    tbl[23] = '{4'b0000, 1'b0, 3'd1, 8, 6'd10, 6'd13, 7'd1};
    tbl[24] = '{4'b1000, 1'b1, 3'd1, 1, 6'd10, 6'd14, 7'd1};  // hit beats press
    tbl[25] = '{4'b0000, 1'b0, 3'd1, 1, 6'd10, 6'd14, 7'd1};

    step(); step();
    rst = 1'b0;
    step();
    check("reset_hold_up", 6'd10, 6'd14, 7'd0);
    step();
    check("held_up_no_fire", 6'd10, 6'd14, 7'd0);

    for (int r = 0; r < 26; r++) begin
      set_btn(tbl[r].btn);
      col  = tbl[r].col;
      tile = tbl[r].tile;
      for (int c = 0; c < tbl[r].n; c++) begin
        step();
        check($sformatf("row%0d_cyc%0d", r, c), tbl[r].ex, tbl[r].ey, tbl[r].es);
      end
      $display("row %0d btn=%b col=%0d tile=%0d -> x=%0d y=%0d score=%0d",
               r, tbl[r].btn, tbl[r].col, tbl[r].tile, fx, fy, score);
    end
    set_btn(4'b0000); col = 1'b0; tile = 3'd1;

    // Climb to the top row, then Up is refused without loading the cooldown.
    for (int i = 0; i < 14; i++) begin
      up = 1'b1; step(); check("climb", 6'd10, 6'(13 - i), 7'd1);
      up = 1'b0; repeat (8) step();
    end
    up = 1'b1; step(); check("up_at_top", 6'd10, 6'd0, 7'd1);
    up = 1'b0; step();
    for (int i = 0; i < 10; i++) begin
      left = 1'b1; step(); check("walk_left", 6'(9 - i), 6'd0, 7'd1);
      left = 1'b0; repeat (8) step();
    end
    left = 1'b1; step(); check("left_at_edge", 6'd0, 6'd0, 7'd1);
    left = 1'b0; col = 1'b1; step(); check("collide_idle", 6'd10, 6'd14, 7'd1);
    col = 1'b0; step();
    $display("edges done x=%0d y=%0d score=%0d", fx, fy, score);

    // Score up to 99 and wrap to 0.
    s = 7'd1;
    for (int i = 0; i < 99; i++) begin
      tile = 3'd4;
      up = 1'b1; step(); check("lily_move", 6'd10, 6'd13, s);
      s = (s == 7'd99) ? 7'd0 : s + 7'd1;
      up = 1'b0; step(); check("lily_score", 6'd10, 6'd14, s);
      tile = 3'd1; repeat (7) step();
    end
    check("score_wrapped", 6'd10, 6'd14, 7'd0);
    $display("score wrap done score=%0d", score);

    // Reset during CHECK overrides the water respawn and clears score.
    tile = 3'd4; up = 1'b1; step(); up = 1'b0; step();
    check("score_one", 6'd10, 6'd14, 7'd1);
    repeat (7) step();
    tile = 3'd2; up = 1'b1; step(); check("pre_reset_move", 6'd10, 6'd13, 7'd1);
    up = 1'b0; rst = 1'b1; step(); check("reset_in_check", 6'd10, 6'd14, 7'd0);
    rst = 1'b0; tile = 3'd1; step();
    up = 1'b1; step(); check("move_after_reset", 6'd10, 6'd13, 7'd0);
    up = 1'b0; step();
    $display("reset mid-move done x=%0d y=%0d", fx, fy);

`ifdef FROG_LIVES_EN
    rst = 1'b1; step(); rst = 1'b0; step();
    checks++;
    if (lives !== 2'd3) begin errors++; $display("FAIL lives_reset: got %0d want 3", lives); end
    for (int i = 0; i < 4; i++) begin
      col = 1'b1; step(); col = 1'b0;
      checks++;
      if (lives !== 2'((i < 3) ? 2 - i : 0)) begin
        errors++;
        $display("FAIL lives_dec%0d: got %0d want %0d", i, lives, (i < 3) ? 2 - i : 0);
      end
      step();
    end
    up = 1'b1; step(); check("locked_up", 6'd10, 6'd14, 7'd0);
    up = 1'b0; step();
    $display("lives done lives=%0d", lives);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
